ps2_host_ctrl: RTL and testbench
================================

Name: ps2_host_ctrl

Overview:
- Host-to-device command sequencer for the PS/2 keyboard port.
- Shares the bidirectional ps2_clk/ps2_data lines with the existing PS/2 receive path.
- Sends one command byte plus an optional argument byte (e.g. LED set ED,xx; reset FF) and checks the keyboard's ACK (FA) / resend (FE) response.
- Holds the receiver off the lines while transmitting, then reports completion or an error code.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000: watchdog, in clk cycles, per waiting phase (20 ms at 50 MHz).
- MAX_RETRY, 3: number of resends allowed on a FE response, per byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ps2_clk_in  in  1  raw PS/2 clock line level.
- ps2_data_in  in  1  raw PS/2 data line level.
- ps2_clk_oe  out  1  1 = pull PS/2 clock low (open-drain).
- ps2_data_oe  out  1  1 = pull PS/2 data low (open-drain).
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_byte  in  8  command byte.
- cmd_has_arg  in  1  an argument byte follows the command.
- arg_byte  in  8  argument byte.
- rx_valid  in  1  one-cycle strobe: receiver has a completed byte.
- rx_byte  in  8  the received byte.
- rx_hold  out  1  1 = receiver must clear its bit counter and ignore the lines.
- done  out  1  one-cycle pulse at end of a transaction.
- err  out  2  valid with done: 00 ok, 01 timeout, 10 retries exhausted, 11 bad ack bit or unexpected response.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Outputs: ps2_clk_oe=0, ps2_data_oe=0, rx_hold=0, done=0, err=00, busy=0, cmd_ready=1.
  - All counters and latches are cleared.
  - Reset mid-transfer releases both lines immediately; no partial-frame recovery.
- Input synchronisation and edge detection:
  - ps2_clk_in and ps2_data_in each pass through a 2-FF synchroniser.
  - A falling edge (fe) is a 1-cycle strobe when the previous synced clock is 1 and the current synced clock is 0.
- Accept: in IDLE, cmd_valid && cmd_ready latches cmd_byte, cmd_has_arg and arg_byte, clears the retry count, and selects cur_byte = cmd_byte.
- State machine:
  - INHIBIT: ps2_clk_oe=1 and rx_hold=1 for exactly INHIBIT_CYCLES cycles.
  - REQ: ps2_data_oe=1 (this is the start bit) and ps2_clk_oe=0 on the same transition. Go to SEND; the bit index is 0.
  - SEND: on each fe, drive the next bit. ps2_data_oe = ~bit.
    - fe 1–8: cur_byte[0..7], LSB first.
    - fe 9: odd parity, i.e. ~^cur_byte.
    - fe 10: stop bit, so release data (oe=0).
    - Then go to ACKB.
  - ACKB: on the next fe, sample synced data. 0 goes to LINE_IDLE; 1 ends with err=11.
  - LINE_IDLE: wait until synced clock=1 and data=1. Then rx_hold=0 and go to WAIT_RESP.
  - WAIT_RESP: act on the first rx_valid:
    - FA: if cur_byte is the command and has_arg is set, set cur_byte = arg, clear retries and go to INHIBIT. Otherwise go to FINISH with err=00.
    - FE: if retry < MAX_RETRY, increment retry and go to INHIBIT with the same byte. Otherwise go to FINISH with err=10.
    - Any other byte: go to FINISH with err=11.
  - FINISH: done=1 for one cycle with err valid, then IDLE. err holds its value until the next accept.
- Watchdog:
  - Counter is cleared on every state entry and on every fe.
  - Active in SEND, ACKB, LINE_IDLE and WAIT_RESP.
  - Reaching TIMEOUT_CYCLES releases both lines, sets rx_hold=0 and goes to FINISH with err=01.
- Simultaneity and ignoring:
  - rx_valid in any state other than WAIT_RESP is ignored.
  - fe in INHIBIT/REQ is ignored.
  - cmd_valid while busy is ignored (cmd_ready=0).
- Line release: ps2_clk_oe and ps2_data_oe are never both asserted outside the INHIBIT→REQ boundary. Both are 0 in LINE_IDLE, WAIT_RESP, FINISH and IDLE.
- Latency: accept → ps2_clk_oe rises next cycle. Last response rx_valid → done is 1 cycle.

Test Plan:
- Single byte FF with a device model that clocks at 12.5 kHz and returns FA:
  - clk held low 5000 cycles, then data low.
  - Device sees bits 1,1,1,1,1,1,1,1, parity 1, stop 1.
  - Response: done with err=00; rx_hold high from accept until the line is idle.
- Command ED, arg 07, device returns FA both times:
  - Second frame bits are 1,1,1,0,0,0,0,0 with parity 0.
  - done pulses exactly once, err=00.
- Device returns FE, FE, then FA for cmd F4: three INHIBIT phases with the same byte, then done with err=00. Separately, FE four times gives err=10 after the 4th FE.
- Device stops clocking after fe 4: both oe go low TIMEOUT_CYCLES after the last fe, done with err=01, then cmd_ready=1.
- Device leaves data high at the ack clock: err=11. Device replies AA instead of FA: err=11.
- rst pulled low while in SEND: both oe are 0 in the same cycle, no done pulse, IDLE with cmd_ready=1. A new command afterwards completes normally.

Source files
------------

// File: rtl/ps2_host_ctrl.sv
// PS/2 host-to-device command sequencer.
// Sends a command byte (optionally followed by an argument byte) to the
// keyboard, checks the ACK bit and the FA/FE response, and holds the shared
// receive path off the lines while the host owns them.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | waiting for a command, cmd_ready high
// INHIBIT     | clock held low, receiver held off
// REQ         | request-to-send: data low (start bit), clock released
// SEND        | shift data, parity and stop bits out on falling edges
// ACKB        | sample the device ACK bit on the next falling edge
// LINE_IDLE   | wait for clock and data both high before releasing receiver
// WAIT_RESP   | wait for the FA/FE response byte from the receiver
// FINISH      | one-cycle done pulse with err valid
module ps2_host_ctrl #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] arg_byte,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       rx_hold,
  output logic       done,
  output logic [1:0] err,
  output logic       busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_SEND      = 3'd3;
  localparam logic [2:0] S_ACKB      = 3'd4;
  localparam logic [2:0] S_LINE_IDLE = 3'd5;
  localparam logic [2:0] S_WAIT_RESP = 3'd6;
  localparam logic [2:0] S_FINISH    = 3'd7;

  localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] INH_LOAD = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic          bit_low_q, bit_low_d;
  logic          on_arg_q, on_arg_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [1:0]    err_q, err_d;
  logic [7:0]    cmd_q, arg_q;
  logic          has_arg_q;
  logic          clk_meta_q, clk_sync_q, clk_prev_q;
  logic          data_meta_q, data_sync_q;
  logic          fe, wd_active, timeout;
  logic [7:0]    cur_byte;

  // Two-flop synchronisers on both raw lines plus a delayed clock for edge detect.
  // Idle lines are high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  assign fe        = clk_prev_q & ~clk_sync_q;
  assign cur_byte  = on_arg_q ? arg_q : cmd_q;
  assign wd_active = (state_q == S_SEND) || (state_q == S_ACKB) ||
                     (state_q == S_LINE_IDLE) || (state_q == S_WAIT_RESP);
  assign timeout   = wd_active && !fe && (timer_q == '0);

  // Next-state logic; the watchdog overrides whatever the waiting state decided.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    bit_low_d = bit_low_q;
    on_arg_d  = on_arg_q;
    retry_d   = retry_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d  = S_INHIBIT;
          on_arg_d = 1'b0;
          retry_d  = '0;
          err_d    = 2'b00;
        end
      end
      S_INHIBIT: begin
        if (timer_q == '0) begin
          state_d   = S_REQ;
          bit_low_d = 1'b1;
        end
      end
      S_REQ: begin
        state_d   = S_SEND;
        bit_idx_d = 4'd0;
      end
      S_SEND: begin
        if (fe) begin
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q < 4'd8) begin
            bit_low_d = ~cur_byte[bit_idx_q[2:0]];
          end else if (bit_idx_q == 4'd8) begin
            // odd parity bit is ~^cur_byte; line is pulled low when it is 0
            bit_low_d = ^cur_byte;
          end else begin
            bit_low_d = 1'b0;
            state_d   = S_ACKB;
          end
        end
      end
      S_ACKB: begin
        if (fe) begin
          if (data_sync_q) begin
            state_d = S_FINISH;
            err_d   = 2'b11;
          end else begin
            state_d = S_LINE_IDLE;
          end
        end
      end
      S_LINE_IDLE: begin
        if (clk_sync_q && data_sync_q) state_d = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (rx_valid) begin
          if (rx_byte == 8'hFA) begin
            if (!on_arg_q && has_arg_q) begin
              on_arg_d = 1'b1;
              retry_d  = '0;
              state_d  = S_INHIBIT;
            end else begin
              state_d = S_FINISH;
              err_d   = 2'b00;
            end
          end else if (rx_byte == 8'hFE) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_d = retry_q + RW'(1);
              state_d = S_INHIBIT;
            end else begin
              state_d = S_FINISH;
              err_d   = 2'b10;
            end
          end else begin
            state_d = S_FINISH;
            err_d   = 2'b11;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (timeout) begin
      state_d   = S_FINISH;
      err_d     = 2'b01;
      bit_low_d = 1'b0;
    end
    // one down-counter serves as inhibit timer and watchdog; reload on entry and on fe
    if ((state_d != state_q) || (fe && wd_active)) begin
      timer_d = (state_d == S_INHIBIT) ? INH_LOAD : TO_LOAD;
    end else if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      bit_low_q <= 1'b0;
      on_arg_q  <= 1'b0;
      retry_q   <= '0;
      err_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      bit_low_q <= bit_low_d;
      on_arg_q  <= on_arg_d;
      retry_q   <= retry_d;
      err_q     <= err_d;
    end
  end

  // Command latch, loaded only on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q     <= 8'h00;
      arg_q     <= 8'h00;
      has_arg_q <= 1'b0;
    end else if ((state_q == S_IDLE) && cmd_valid) begin
      cmd_q     <= cmd_byte;
      arg_q     <= arg_byte;
      has_arg_q <= cmd_has_arg;
    end
  end

  // Outputs decode straight from state so reset releases the lines at once.
  assign ps2_clk_oe  = (state_q == S_INHIBIT);
  assign ps2_data_oe = (state_q == S_REQ) || ((state_q == S_SEND) && bit_low_q);
  assign rx_hold     = (state_q == S_INHIBIT) || (state_q == S_REQ) || (state_q == S_SEND) ||
                       (state_q == S_ACKB) || (state_q == S_LINE_IDLE);
  assign done        = (state_q == S_FINISH);
  assign err         = err_q;
  assign busy        = (state_q != S_IDLE);
  assign cmd_ready   = (state_q == S_IDLE);

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed bench for ps2_host_ctrl with a simple device model on the lines.
module tb_ps2_host_ctrl;

  localparam int INH = 20;
  localparam int TO  = 300;
  localparam int H   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_byte = 8'h00;
  logic       cmd_has_arg = 1'b0;
  logic [7:0] arg_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_hold, done, busy;
  logic [1:0] err;

  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int         vectors = 0;
  int         miscompares = 0;
  int         done_cnt = 0;
  logic [1:0] last_err = 2'b00;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_ctrl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_byte(cmd_byte), .cmd_has_arg(cmd_has_arg), .arg_byte(arg_byte),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_hold(rx_hold),
    .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      last_err = err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic [7:0] c, input logic h, input logic [7:0] a);
    @(negedge clk);
    chk("cmd_ready in idle", 32'(cmd_ready), 1);
    cmd_byte = c; cmd_has_arg = h; arg_byte = a; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("clk_oe after accept", 32'(ps2_clk_oe), 1);
    chk("rx_hold after accept", 32'(rx_hold), 1);
    chk("cmd_ready while busy", 32'(cmd_ready), 0);
  endtask

  // Waits for request-to-send, then clocks nclk falling edges (11 = full frame with ack).
  task automatic dev_frame(input int nclk, input logic ack_low, output logic [9:0] bits, output int inh);
    int n;
    bits = '0; inh = 0; n = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < 2000) begin
      if (ps2_clk_oe) inh++;
      @(negedge clk);
      n++;
    end
    chk("request-to-send seen", 32'(n < 2000), 1);
    repeat (H) @(negedge clk);
    chk("start bit level", 32'(ps2_data_in), 0);
    for (int k = 1; k <= nclk && k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      bits[k-1] = ps2_data_in;
      dev_clk = 1'b1;
      repeat (H) @(negedge clk);
    end
    if (nclk >= 11) begin
      dev_data = ~ack_low;
      dev_clk  = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      repeat (H) @(negedge clk);
    end
  endtask

  task automatic respond(input logic [7:0] b);
    int n;
    n = 0;
    while (rx_hold && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rx_hold released at line idle", 32'(rx_hold), 0);
    @(negedge clk);
    rx_byte = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic finish_chk(input string tag, input logic [1:0] exp_err);
    chk({tag, " done"}, 32'(done), 1);
    chk({tag, " err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    chk({tag, " done is one cycle"}, 32'(done), 0);
    chk({tag, " back to idle"}, 32'(cmd_ready), 1);
    chk({tag, " err held"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    logic [9:0] bits;
    int         inh;
    int         d0;
    int         n;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset clk_oe", 32'(ps2_clk_oe), 0);
    chk("reset data_oe", 32'(ps2_data_oe), 0);
    chk("reset rx_hold", 32'(rx_hold), 0);
    chk("reset done", 32'(done), 0);
    chk("reset err", 32'(err), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset cmd_ready", 32'(cmd_ready), 1);
    rst = 1'b1;

    // single byte FF, FA
    d0 = done_cnt;
    start_cmd(8'hFF, 1'b0, 8'h00);
    dev_frame(11, 1'b1, bits, inh);
    chk("FF inhibit cycles", 32'(inh), INH);
    chk("FF frame bits", 32'(bits), 32'h3FF);
    respond(8'hFA);
    finish_chk("FF", 2'b00);
    chk("FF done count", 32'(done_cnt - d0), 1);

    // ED 07, FA twice
    d0 = done_cnt;
    start_cmd(8'hED, 1'b1, 8'h07);
    dev_frame(11, 1'b1, bits, inh);
    chk("ED frame bits", 32'(bits), 32'h3ED);
    respond(8'hFA);
    chk("ED still busy after first FA", 32'(busy), 1);
    chk("ED no done after first FA", 32'(done), 0);
    dev_frame(11, 1'b1, bits, inh);
    chk("ED arg inhibit cycles", 32'(inh), INH);
    chk("ED arg frame bits", 32'(bits), 32'h207);
    respond(8'hFA);
    finish_chk("ED07", 2'b00);
    chk("ED07 done count", 32'(done_cnt - d0), 1);

    // F4 with FE, FE, FA
    start_cmd(8'hF4, 1'b0, 8'h00);
    for (int r = 0; r < 3; r++) begin
      dev_frame(11, 1'b1, bits, inh);
      chk("F4 retry inhibit cycles", 32'(inh), INH);
      chk("F4 retry frame bits", 32'(bits), 32'h2F4);
      respond((r < 2) ? 8'hFE : 8'hFA);
    end
    finish_chk("F4 resend", 2'b00);

    // F4 with FE four times
    start_cmd(8'hF4, 1'b0, 8'h00);
    for (int r = 0; r < 4; r++) begin
      dev_frame(11, 1'b1, bits, inh);
      chk("F4 exhaust frame bits", 32'(bits), 32'h2F4);
      respond(8'hFE);
      if (r < 3) chk("F4 exhaust still busy", 32'(busy), 1);
    end
    finish_chk("F4 exhaust", 2'b10);

    // device stops clocking after fe 4
    start_cmd(8'hF4, 1'b0, 8'h00);
    dev_frame(4, 1'b1, bits, inh);
    chk("stall data_oe held", 32'(ps2_data_oe), 1);
    n = 0;
    while (!done && n < 2 * TO) begin
      @(negedge clk);
      n++;
    end
    chk("stall timeout window", 32'((n >= TO - 2*H - 4) && (n <= TO - 2*H + 8)), 1);
    chk("stall data_oe released", 32'(ps2_data_oe), 0);
    chk("stall clk_oe released", 32'(ps2_clk_oe), 0);
    chk("stall rx_hold released", 32'(rx_hold), 0);
    finish_chk("stall", 2'b01);

    // ack bit left high
    d0 = done_cnt;
    start_cmd(8'hFF, 1'b0, 8'h00);
    dev_frame(11, 1'b0, bits, inh);
    chk("bad ack done count", 32'(done_cnt - d0), 1);
    chk("bad ack err", 32'(last_err), 32'h3);
    chk("bad ack idle", 32'(cmd_ready), 1);

    // unexpected response AA
    start_cmd(8'hFF, 1'b0, 8'h00);
    dev_frame(11, 1'b1, bits, inh);
    respond(8'hAA);
    finish_chk("AA reply", 2'b11);

    // reset while in SEND
    start_cmd(8'hF4, 1'b0, 8'h00);
    dev_frame(2, 1'b1, bits, inh);
    chk("pre-reset data_oe", 32'(ps2_data_oe), 1);
    d0 = done_cnt;
    rst = 1'b0;
    #1;
    chk("mid reset data_oe", 32'(ps2_data_oe), 0);
    chk("mid reset clk_oe", 32'(ps2_clk_oe), 0);
    chk("mid reset cmd_ready", 32'(cmd_ready), 1);
    repeat (3) @(negedge clk);
    chk("mid reset no done", 32'(done_cnt - d0), 0);
    rst = 1'b1;
    start_cmd(8'hFF, 1'b0, 8'h00);
    dev_frame(11, 1'b1, bits, inh);
    chk("post reset frame bits", 32'(bits), 32'h3FF);
    respond(8'hFA);
    finish_chk("post reset", 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
